// File: rtl/adder_core.sv
// rtl/adder_core.sv - adder with combinational clear and registered sum/carry/overflow
module adder_core #(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             Cout,
   output logic [WIDTH-1:0] S,
   input  logic             clr,
   input  logic             en,
   input  logic             clk,
   input  logic             Reset,
   output logic [WIDTH-1:0] S_q,
   output logic             Cout_q,
   output logic             Ovf_q
);

   logic [WIDTH:0] sum_full;
   logic           ovf;

   // The sum path never touches clk/Reset/en so WIDTH=1 instances can ripple Cout->Cin.
   always_comb begin
      sum_full = '0;
      if (!clr) begin
         sum_full = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
      end
   end

   assign S    = sum_full[WIDTH-1:0];
   assign Cout = sum_full[WIDTH];
   assign ovf  = !clr && (A[WIDTH-1] == B[WIDTH-1]) && (S[WIDTH-1] != A[WIDTH-1]);

   always_ff @(posedge clk) begin
      if (!Reset) begin
         S_q    <= '0;
         Cout_q <= 1'b0;
         Ovf_q  <= 1'b0;
      end else if (en) begin
         S_q    <= S;
         Cout_q <= Cout;
         Ovf_q  <= ovf;
      end
   end

endmodule

// File: tb/tb_adder_core.sv
// tb/tb_adder_core.sv - self-checking bench for adder_core
module tb_adder_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int   total = 0;
   int   bad   = 0;
   logic reset;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // WIDTH=1 single instance
   logic a1, b1, c1, s1, co1, sq1, cq1, oq1;
   adder_core #(.WIDTH(1)) u_w1 (
      .A(a1), .B(b1), .Cin(c1), .Cout(co1), .S(s1), .clr(1'b0), .en(1'b0),
      .clk(clk), .Reset(reset), .S_q(sq1), .Cout_q(cq1), .Ovf_q(oq1));

   // nine-stage ripple chain of WIDTH=1 instances
   logic [8:0] ca, cb;
   wire  [8:0] cs, dq_s, dq_c, dq_o;
   wire  [9:0] carry;
   assign carry[0] = 1'b0;
   for (genvar g = 0; g < 9; g++) begin : g_chain
      adder_core #(.WIDTH(1)) u_bit (
         .A(ca[g]), .B(cb[g]), .Cin(carry[g]), .Cout(carry[g+1]), .S(cs[g]),
         .clr(1'b0), .en(1'b0), .clk(clk), .Reset(reset),
         .S_q(dq_s[g]), .Cout_q(dq_c[g]), .Ovf_q(dq_o[g]));
   end

   // WIDTH=9 clear check
   logic [8:0] a9, b9, s9, sq9;
   logic       c9, clr9, co9, cq9, oq9;
   adder_core #(.WIDTH(9)) u_w9 (
      .A(a9), .B(b9), .Cin(c9), .Cout(co9), .S(s9), .clr(clr9), .en(1'b0),
      .clk(clk), .Reset(reset), .S_q(sq9), .Cout_q(cq9), .Ovf_q(oq9));

   // WIDTH=8 registered path
   logic [7:0] a8, b8, s8, sq8;
   logic       c8, clr8, en8, co8, cq8, oq8;
   adder_core #(.WIDTH(8)) u_w8 (
      .A(a8), .B(b8), .Cin(c8), .Cout(co8), .S(s8), .clr(clr8), .en(en8),
      .clk(clk), .Reset(reset), .S_q(sq8), .Cout_q(cq8), .Ovf_q(oq8));

   typedef struct {
      logic [7:0] s;
      logic       c;
      logic       o;
   } reg_t;

   reg_t q[$];
   reg_t mdl = '{s: 8'h00, c: 1'b0, o: 1'b0};
   bit   primed = 0;

   task automatic step8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic clr, input logic en, input logic rst);
      logic [8:0] sum;
      logic       ov;
      reg_t       nxt, got;
      @(negedge clk);
      a8 = a; b8 = b; c8 = cin; clr8 = clr; en8 = en; reset = rst;
      #1;
      sum = clr ? 9'h000 : ({1'b0, a} + {1'b0, b} + {8'h00, cin});
      ov  = !clr && (a[7] == b[7]) && (sum[7] != a[7]);
      chk("w8_comb", {co8, s8}, sum);
      if (primed) chk("w8_pre_edge", {sq8, cq8, oq8}, {mdl.s, mdl.c, mdl.o});
      if (!rst)    nxt = '{s: 8'h00, c: 1'b0, o: 1'b0};
      else if (en) nxt = '{s: sum[7:0], c: sum[8], o: ov};
      else         nxt = mdl;
      mdl = nxt;
      q.push_back(nxt);
      @(posedge clk);
      #1;
      chk("w8_comb_post", {co8, s8}, sum);
      got = q.pop_front();
      chk("w8_regs", {sq8, cq8, oq8}, {got.s, got.c, got.o});
      primed = 1;
   endtask

   initial begin
      reset = 1'b0;
      a1 = 0; b1 = 0; c1 = 0; ca = '0; cb = '0;
      a9 = '0; b9 = '0; c9 = 0; clr9 = 0;
      a8 = '0; b8 = '0; c8 = 0; clr8 = 0; en8 = 0;

      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = i[2:0];
         {a1, b1, c1} = v;
         #1;
         chk("w1_exhaustive", {co1, s1}, {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]});
      end

      ca = 9'h1FF; cb = 9'h001; #1;
      chk("chain_1ff_001", {carry[9], cs}, 10'h200);
      ca = 9'h0AA; cb = 9'h055; #1;
      chk("chain_0aa_055", {carry[9], cs}, 10'h0FF);
      for (int i = 0; i < (1 << 18); i++) begin
         logic [17:0] v;
         v = i[17:0];
         ca = v[17:9]; cb = v[8:0];
         #1;
         chk("chain_sweep", {carry[9], cs}, {1'b0, v[17:9]} + {1'b0, v[8:0]});
      end

      a9 = 9'h1FF; b9 = 9'h1FF; c9 = 1; clr9 = 1; #1;
      chk("w9_clr", {co9, s9}, 10'h000);
      clr9 = 0; #1;
      chk("w9_wrap", {co9, s9}, 10'h3FF);

      step8(8'h00, 8'h00, 0, 0, 1, 0);
      step8(8'hFF, 8'hFF, 1, 0, 1, 0);
      step8(8'h7F, 8'h01, 0, 0, 1, 1);
      chk("w8_reg_7f01", {sq8, cq8, oq8}, {8'h80, 1'b0, 1'b1});
      step8(8'h12, 8'h34, 1, 0, 0, 1);
      step8(8'hFF, 8'h01, 0, 0, 1, 1);
      step8(8'h80, 8'h80, 0, 0, 1, 1);
      step8(8'hFF, 8'hFF, 1, 1, 1, 1);
      step8(8'hFF, 8'hFF, 1, 0, 1, 1);
      step8(8'h55, 8'hAA, 0, 0, 1, 0);
      step8(8'h40, 8'h40, 0, 0, 1, 1);
      step8(8'h01, 8'h02, 1, 0, 0, 0);
      for (int i = 0; i < 40; i++) begin
         step8(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0),
               1'($urandom), ($urandom_range(0, 5) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
